// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg -- shared constants and types for the rv_data_bus slice.
//   XLEN        : data/address width of the bus
//   BUS_MAX_SLV : largest slave count a bus instance may be built with
//   slv_idx_t   : slave index, wide enough to also encode the DECERR target
//                 (index == NSLV, at most BUS_MAX_SLV)
// -----------------------------------------------------------------------------
package rv_pkg;

  localparam int XLEN        = 32;
  localparam int BUS_MAX_SLV = 8;
  localparam int SLV_IDX_W   = $clog2(BUS_MAX_SLV + 1);

  typedef logic [SLV_IDX_W-1:0] slv_idx_t;

endpackage

// File: rtl/rv_data_bus_if.sv
// -----------------------------------------------------------------------------
// rv_data_bus_if -- master-side request/response bundle of the data bus.
//   data_req_i/we_i/be_i/addr_i/wdata_i : request from the master
//   data_gnt_o                          : request accepted this cycle
//   data_rvalid_o/rdata_o/err_o         : in-order response to the master
// Modports: master (drives requests), slave (the bus, drives grant/response).
// Signal names keep the bus-side direction suffixes used across the codebase.
// -----------------------------------------------------------------------------
interface rv_data_bus_if;
  import rv_pkg::*;

  logic              data_req_i;
  logic              data_we_i;
  logic [XLEN/8-1:0] data_be_i;
  logic [XLEN-1:0]   data_addr_i;
  logic [XLEN-1:0]   data_wdata_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [XLEN-1:0]   data_rdata_o;
  logic              data_err_o;

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

endinterface

// File: rtl/rv_bus_fifo.sv
// -----------------------------------------------------------------------------
// rv_bus_fifo -- small in-order FIFO holding the target of every granted
// request until its response has been returned.
//   clk, rst_n      : clock, synchronous active-low reset
//   push, push_data : write an entry (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   full, empty     : occupancy flags
//   head            : oldest entry, valid only when !empty
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
// -----------------------------------------------------------------------------
module rv_bus_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only ever read after
  // it has been written, and the occupancy counter guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/rv_data_bus.sv
// -----------------------------------------------------------------------------
// rv_data_bus -- one master to NSLV slaves data bus with address decode,
// in-order response routing and decode-error generation.
//   clk_i, arstn_i   : clock, synchronous active-low reset
//   bus (slave mp)   : master request / grant / response bundle
//   slv_req_o        : one-hot request to the decoded slave
//   slv_we_o/be_o/addr_o/wdata_o : shared request fields to all slaves
//   slv_rvalid_i/rdata_i         : per-slave responses
// Outstanding requests are tracked in rv_bus_fifo; a new request is only
// granted while it targets the same slave as the previous grant (or nothing is
// outstanding), so responses come back in order without reordering buffers.
// Optional feature: define RV_BUS_TIMEOUT_EN to add a response watchdog that
// answers a silent slave with an error after TIMEOUT_CYCLES waiting cycles.
// -----------------------------------------------------------------------------
module rv_data_bus
  import rv_pkg::*;
#(
  parameter int                         NSLV           = 4,
  parameter int                         MAX_OUTST      = 2,
  // Element i is slave i (packed order: highest index first in the literal).
  parameter logic [NSLV-1:0][XLEN-1:0]  SLV_BASE       = {32'h3000_0000, 32'h2000_0000,
                                                          32'h1000_0000, 32'h0000_0000},
  parameter logic [NSLV-1:0][XLEN-1:0]  SLV_MASK       = {4{32'hF000_0000}},
  parameter int                         TIMEOUT_CYCLES = 255
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  rv_data_bus_if.slave               bus,
  output logic [NSLV-1:0]            slv_req_o,
  output logic                       slv_we_o,
  output logic [XLEN/8-1:0]          slv_be_o,
  output logic [XLEN-1:0]            slv_addr_o,
  output logic [XLEN-1:0]            slv_wdata_o,
  input  logic [NSLV-1:0]            slv_rvalid_i,
  input  logic [NSLV-1:0][XLEN-1:0]  slv_rdata_i
);

  localparam slv_idx_t DECERR = slv_idx_t'(NSLV);

  if (NSLV < 1 || NSLV > BUS_MAX_SLV) begin : g_bad_nslv
    $error("rv_data_bus: NSLV out of range 1..%0d", BUS_MAX_SLV);
  end
  if (MAX_OUTST < 1 || MAX_OUTST > 8) begin : g_bad_outst
    $error("rv_data_bus: MAX_OUTST out of range 1..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("rv_data_bus: TIMEOUT_CYCLES out of range 1..65535");
  end

  slv_idx_t target, last_target_q, head;
  logic     full, empty, gnt, pop, stray_hit, stray_q, wd_fire;

  // Address decode: scan from the top so the lowest matching index wins.
  always_comb begin
    target = DECERR;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((bus.data_addr_i & SLV_MASK[i]) == SLV_BASE[i]) target = slv_idx_t'(i);
    end
  end

  // A full FIFO blocks the grant even when a pop happens in the same cycle,
  // keeping the grant path free of the response path. Outputs are held at 0
  // while reset is asserted.
  assign gnt = arstn_i & bus.data_req_i & ~full & (empty | (target == last_target_q));
  assign bus.data_gnt_o = gnt;

  always_comb begin
    slv_req_o = '0;
    for (int t = 0; t < NSLV; t++) slv_req_o[t] = gnt & (target == slv_idx_t'(t));
  end

  assign slv_we_o    = arstn_i & bus.data_we_i;
  assign slv_be_o    = arstn_i ? bus.data_be_i    : '0;
  assign slv_addr_o  = arstn_i ? bus.data_addr_i  : '0;
  assign slv_wdata_o = arstn_i ? bus.data_wdata_i : '0;

  rv_bus_fifo #(
    .WIDTH ($bits(slv_idx_t)),
    .DEPTH (MAX_OUTST)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (arstn_i),
    .push      (gnt),
    .push_data (target),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  // Response routing: only the slave at the FIFO head may answer; any other
  // rvalid is dropped and remembered in stray_q.
  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    bus.data_rvalid_o = 1'b0;
    bus.data_err_o    = 1'b0;
    bus.data_rdata_o  = '0;
    pop               = 1'b0;
    stray_hit         = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (slv_rvalid_i[i] && (empty || head != slv_idx_t'(i))) stray_hit = 1'b1;
    end
    if (arstn_i && !empty) begin
      if (head == DECERR) begin
        bus.data_rvalid_o = 1'b1;
        bus.data_err_o    = 1'b1;
        pop               = 1'b1;
      end else begin
        for (int i = 0; i < NSLV; i++) begin
          if (head == slv_idx_t'(i) && slv_rvalid_i[i]) begin
            bus.data_rvalid_o = 1'b1;
            bus.data_rdata_o  = slv_rdata_i[i];
            pop               = 1'b1;
          end
        end
        // A real response in the same cycle takes precedence over the watchdog.
        if (!pop && wd_fire) begin
          bus.data_rvalid_o = 1'b1;
          bus.data_err_o    = 1'b1;
          pop               = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      last_target_q <= '0;
      stray_q       <= 1'b0;
    end else begin
      if (gnt)       last_target_q <= target;
      if (stray_hit) stray_q       <= 1'b1;
    end
  end

`ifdef RV_BUS_TIMEOUT_EN
  // Counts cycles the head has waited; it can never pass TIMEOUT_CYCLES
  // because reaching it forces a pop, which clears it.
  logic [15:0] wd_cnt_q;

  assign wd_fire = (wd_cnt_q == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i) begin
    if (!arstn_i)    wd_cnt_q <= '0;
    else if (pop)    wd_cnt_q <= '0;
    else if (!empty) wd_cnt_q <= wd_cnt_q + 16'd1;
  end
`else
  assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_rv_data_bus.sv
// -----------------------------------------------------------------------------
// tb_rv_data_bus -- self-checking bench for rv_data_bus (NSLV=4, MAX_OUTST=2,
// TIMEOUT_CYCLES=10). Directed scenario tables followed by a randomized run
// against a queue-based model of the bus. Inputs change just after the falling
// edge; outputs are sampled 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_rv_data_bus;
  import rv_pkg::*;

  localparam int NSLV      = 4;
  localparam int MAX_OUTST = 2;
  localparam int TO        = 10;
  localparam int DEC       = NSLV;

  typedef logic [38:0] obs_t;  // {gnt, slv_req[3:0], rvalid, err, rdata[31:0]}
  typedef struct {
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic [3:0]  rv;
    logic [31:0] rd;
    obs_t        exp;
  } step_t;

  localparam obs_t Z = '0;

  logic                      clk_i = 1'b0;
  logic                      arstn_i = 1'b0;
  logic [NSLV-1:0]           slv_req_o;
  logic                      slv_we_o;
  logic [XLEN/8-1:0]         slv_be_o;
  logic [XLEN-1:0]           slv_addr_o, slv_wdata_o;
  logic [NSLV-1:0]           slv_rvalid_i;
  logic [NSLV-1:0][XLEN-1:0] slv_rdata_i;

  int n_cmp = 0;
  int n_mis = 0;

  rv_data_bus_if bus ();

  rv_data_bus #(
    .NSLV           (NSLV),
    .MAX_OUTST      (MAX_OUTST),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .bus          (bus),
    .slv_req_o    (slv_req_o),
    .slv_we_o     (slv_we_o),
    .slv_be_o     (slv_be_o),
    .slv_addr_o   (slv_addr_o),
    .slv_wdata_o  (slv_wdata_o),
    .slv_rvalid_i (slv_rvalid_i),
    .slv_rdata_i  (slv_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic obs_t mk(input logic g, input logic [3:0] s, input logic v,
                              input logic e, input logic [31:0] d);
    return {g, s, v, e, d};
  endfunction

  function automatic step_t st(input logic r, input logic q, input logic [31:0] a,
                               input logic [3:0] v, input logic [31:0] d, input obs_t e);
    step_t s;
    s.rst_n = r; s.req = q; s.addr = a; s.rv = v; s.rd = d; s.exp = e;
    return s;
  endfunction

  function automatic obs_t observe();
    return {bus.data_gnt_o, slv_req_o, bus.data_rvalid_o, bus.data_err_o, bus.data_rdata_o};
  endfunction

  // Applies one cycle of stimulus; responding slaves return s.rd, others noise.
  task automatic apply(input step_t s);
    @(negedge clk_i);
    arstn_i          = s.rst_n;
    bus.data_req_i   = s.req;
    bus.data_addr_i  = s.addr;
    bus.data_we_i    = 1'($urandom);
    bus.data_be_i    = 4'($urandom);
    bus.data_wdata_i = $urandom;
    slv_rvalid_i     = s.rv;
    for (int i = 0; i < NSLV; i++) slv_rdata_i[i] = s.rv[i] ? s.rd : $urandom;
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    s.push_back(st(1'b0, 1'b1, 32'h1000_0000, 4'b1111, 32'h1111_1111, Z));
    s.push_back(st(1'b0, 1'b1, 32'h5000_0000, 4'b0101, 32'h2222_2222, Z));
    s.push_back(st(1'b1, 1'b0, 32'h0000_0000, 4'b0000, 32'h0, Z));
    foreach (s[i]) begin
      apply(s[i]);
      n_cmp++;
      if (observe() !== s[i].exp) begin
        n_mis++;
        $display("FAIL reset step %0d: got %h, expected %h", i, observe(), s[i].exp);
      end
      if (!s[i].rst_n) begin
        n_cmp++;
        if ({slv_we_o, slv_be_o, slv_addr_o, slv_wdata_o} !== '0) begin
          n_mis++;
          $display("FAIL reset_passthru step %0d: got %h, expected 0", i,
                   {slv_we_o, slv_be_o, slv_addr_o, slv_wdata_o});
        end
      end
    end
  endtask

  task automatic test_read();
    step_t s[$];
    s.push_back(st(1'b1, 1'b1, 32'h1000_0004, 4'b0000, 32'h0, mk(1'b1, 4'b0010, 1'b0, 1'b0, 32'h0)));
    s.push_back(st(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, Z));
    s.push_back(st(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, Z));
    s.push_back(st(1'b1, 1'b0, 32'h0, 4'b0010, 32'hDEAD_BEEF, mk(1'b0, 4'b0, 1'b1, 1'b0, 32'hDEAD_BEEF)));
    s.push_back(st(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, Z));
    foreach (s[i]) begin
      apply(s[i]);
      n_cmp++;
      if (observe() !== s[i].exp) begin
        n_mis++;
        $display("FAIL read step %0d: got %h, expected %h", i, observe(), s[i].exp);
      end
    end
  endtask

  task automatic test_decerr();
    step_t s[$];
    s.push_back(st(1'b1, 1'b1, 32'h5000_0000, 4'b0000, 32'h0, mk(1'b1, 4'b0, 1'b0, 1'b0, 32'h0)));
    s.push_back(st(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, mk(1'b0, 4'b0, 1'b1, 1'b1, 32'h0)));
    s.push_back(st(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, Z));
    foreach (s[i]) begin
      apply(s[i]);
      n_cmp++;
      if (observe() !== s[i].exp) begin
        n_mis++;
        $display("FAIL decerr step %0d: got %h, expected %h", i, observe(), s[i].exp);
      end
    end
  endtask

  task automatic test_full();
    step_t s[$];
    logic [31:0] a = 32'h0000_0010;
    s.push_back(st(1'b1, 1'b1, a, 4'b0000, 32'h0, mk(1'b1, 4'b0001, 1'b0, 1'b0, 32'h0)));
    s.push_back(st(1'b1, 1'b1, a, 4'b0000, 32'h0, mk(1'b1, 4'b0001, 1'b0, 1'b0, 32'h0)));
    s.push_back(st(1'b1, 1'b1, a, 4'b0000, 32'h0, Z));
    s.push_back(st(1'b1, 1'b1, a, 4'b0000, 32'h0, Z));
    s.push_back(st(1'b1, 1'b1, a, 4'b0001, 32'h1111_0000, mk(1'b0, 4'b0, 1'b1, 1'b0, 32'h1111_0000)));
    s.push_back(st(1'b1, 1'b1, a, 4'b0000, 32'h0, mk(1'b1, 4'b0001, 1'b0, 1'b0, 32'h0)));
    s.push_back(st(1'b1, 1'b0, a, 4'b0001, 32'h2222_0000, mk(1'b0, 4'b0, 1'b1, 1'b0, 32'h2222_0000)));
    s.push_back(st(1'b1, 1'b0, a, 4'b0001, 32'h3333_0000, mk(1'b0, 4'b0, 1'b1, 1'b0, 32'h3333_0000)));
    s.push_back(st(1'b1, 1'b0, a, 4'b0000, 32'h0, Z));
    foreach (s[i]) begin
      apply(s[i]);
      n_cmp++;
      if (observe() !== s[i].exp) begin
        n_mis++;
        $display("FAIL full step %0d: got %h, expected %h", i, observe(), s[i].exp);
      end
    end
  endtask

  task automatic test_switch();
    step_t s[$];
    s.push_back(st(1'b1, 1'b1, 32'h0000_0020, 4'b0000, 32'h0, mk(1'b1, 4'b0001, 1'b0, 1'b0, 32'h0)));
    s.push_back(st(1'b1, 1'b1, 32'h2000_0000, 4'b0000, 32'h0, Z));
    s.push_back(st(1'b1, 1'b1, 32'h2000_0000, 4'b0000, 32'h0, Z));
    s.push_back(st(1'b1, 1'b1, 32'h2000_0000, 4'b0001, 32'h4444_4444, mk(1'b0, 4'b0, 1'b1, 1'b0, 32'h4444_4444)));
    s.push_back(st(1'b1, 1'b1, 32'h2000_0000, 4'b0000, 32'h0, mk(1'b1, 4'b0100, 1'b0, 1'b0, 32'h0)));
    s.push_back(st(1'b1, 1'b0, 32'h0, 4'b0100, 32'h5555_5555, mk(1'b0, 4'b0, 1'b1, 1'b0, 32'h5555_5555)));
    s.push_back(st(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, Z));
    foreach (s[i]) begin
      apply(s[i]);
      n_cmp++;
      if (observe() !== s[i].exp) begin
        n_mis++;
        $display("FAIL switch step %0d: got %h, expected %h", i, observe(), s[i].exp);
      end
    end
  endtask

  // Silent slave 3: with the watchdog an error arrives after TO waiting
  // cycles and the late answer is stray; without it the bus keeps waiting.
  task automatic test_timeout();
    step_t s[$];
    step_t late[$];
    s.push_back(st(1'b1, 1'b1, 32'h3000_0000, 4'b0000, 32'h0, mk(1'b1, 4'b1000, 1'b0, 1'b0, 32'h0)));
`ifdef RV_BUS_TIMEOUT_EN
    for (int k = 0; k < TO; k++) s.push_back(st(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, Z));
    s.push_back(st(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, mk(1'b0, 4'b0, 1'b1, 1'b1, 32'h0)));
    s.push_back(st(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, Z));
    late.push_back(st(1'b1, 1'b0, 32'h0, 4'b1000, 32'h1234_5678, Z));
    late.push_back(st(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, Z));
`else
    for (int k = 0; k < 3 * TO; k++) s.push_back(st(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, Z));
    s.push_back(st(1'b1, 1'b0, 32'h0, 4'b1000, 32'h1234_5678, mk(1'b0, 4'b0, 1'b1, 1'b0, 32'h1234_5678)));
    s.push_back(st(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, Z));
`endif
    foreach (s[i]) begin
      apply(s[i]);
      n_cmp++;
      if (observe() !== s[i].exp) begin
        n_mis++;
        $display("FAIL timeout step %0d: got %h, expected %h", i, observe(), s[i].exp);
      end
    end
    n_cmp++;
    if (dut.stray_q !== 1'b0) begin
      n_mis++;
      $display("FAIL timeout_stray_clear: got %b, expected 0", dut.stray_q);
    end
    foreach (late[i]) begin
      apply(late[i]);
      n_cmp++;
      if (observe() !== late[i].exp) begin
        n_mis++;
        $display("FAIL timeout_late step %0d: got %h, expected %h", i, observe(), late[i].exp);
      end
    end
    if (late.size() != 0) begin
      n_cmp++;
      if (dut.stray_q !== 1'b1) begin
        n_mis++;
        $display("FAIL timeout_stray_set: got %b, expected 1", dut.stray_q);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t s[$];
    step_t t[$];
    s.push_back(st(1'b1, 1'b1, 32'h1000_0000, 4'b0000, 32'h0, mk(1'b1, 4'b0010, 1'b0, 1'b0, 32'h0)));
    s.push_back(st(1'b1, 1'b1, 32'h1000_0004, 4'b0000, 32'h0, mk(1'b1, 4'b0010, 1'b0, 1'b0, 32'h0)));
    s.push_back(st(1'b0, 1'b1, 32'h2000_0000, 4'b0000, 32'h0, Z));
    s.push_back(st(1'b1, 1'b0, 32'h0, 4'b0010, 32'h7777_7777, Z));
    s.push_back(st(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, Z));
    t.push_back(st(1'b1, 1'b1, 32'h2000_0000, 4'b0000, 32'h0, mk(1'b1, 4'b0100, 1'b0, 1'b0, 32'h0)));
    t.push_back(st(1'b1, 1'b0, 32'h0, 4'b0100, 32'hCAFE_F00D, mk(1'b0, 4'b0, 1'b1, 1'b0, 32'hCAFE_F00D)));
    t.push_back(st(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, Z));
    foreach (s[i]) begin
      apply(s[i]);
      n_cmp++;
      if (observe() !== s[i].exp) begin
        n_mis++;
        $display("FAIL reset_mid step %0d: got %h, expected %h", i, observe(), s[i].exp);
      end
    end
    n_cmp++;
    if (dut.stray_q !== 1'b1) begin
      n_mis++;
      $display("FAIL reset_mid_stray: got %b, expected 1", dut.stray_q);
    end
    foreach (t[i]) begin
      apply(t[i]);
      n_cmp++;
      if (observe() !== t[i].exp) begin
        n_mis++;
        $display("FAIL reset_mid_after step %0d: got %h, expected %h", i, observe(), t[i].exp);
      end
    end
  endtask

  // Random traffic against a model holding the outstanding targets in a queue.
  task automatic test_random();
    int          q[$];
    int          last, wait_cnt, tgt, region;
    bit          stray, e_g, e_v, e_e, pop;
    logic [31:0] a, e_d;
    logic [31:0] rd [NSLV];
    logic [3:0]  rv, e_s;
    logic        req, we;
    last = 0; wait_cnt = 0; stray = 1'b0;
    apply(st(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, Z));
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_i);
      arstn_i = 1'b1;
      req     = ($urandom_range(0, 9) < 7);
      we      = 1'($urandom);
      region  = $urandom_range(0, 5);
      a       = $urandom;
      a[31:28] = (region < 4) ? 4'(region) : 4'($urandom_range(4, 15));
      for (int i = 0; i < NSLV; i++) begin
        rv[i] = ($urandom_range(0, 3) == 0);
        rd[i] = $urandom;
        slv_rdata_i[i] = rd[i];
      end
      bus.data_req_i   = req;
      bus.data_we_i    = we;
      bus.data_addr_i  = a;
      bus.data_be_i    = 4'($urandom);
      bus.data_wdata_i = $urandom;
      slv_rvalid_i     = rv;
      #1;
      tgt = (a[31:28] < 4) ? int'(a[31:28]) : DEC;
      e_v = 1'b0; e_e = 1'b0; e_d = '0; pop = 1'b0;
      if (q.size() > 0) begin
        if (q[0] == DEC) begin
          e_v = 1'b1; e_e = 1'b1; pop = 1'b1;
        end else if (rv[q[0]]) begin
          e_v = 1'b1; e_d = rd[q[0]]; pop = 1'b1;
        end
`ifdef RV_BUS_TIMEOUT_EN
        else if (wait_cnt == TO) begin
          e_v = 1'b1; e_e = 1'b1; pop = 1'b1;
        end
`endif
      end
      e_g = req && (q.size() < MAX_OUTST) && (q.size() == 0 || tgt == last);
      e_s = (e_g && tgt < NSLV) ? 4'(1 << tgt) : 4'b0000;
      n_cmp++;
      if ({observe(), slv_addr_o, slv_we_o} !== {mk(e_g, e_s, e_v, e_e, e_d), a, we}) begin
        n_mis++;
        $display("FAIL random cycle %0d: got %h/%h/%b, expected %h/%h/%b", c,
                 observe(), slv_addr_o, slv_we_o, mk(e_g, e_s, e_v, e_e, e_d), a, we);
      end
      for (int i = 0; i < NSLV; i++) begin
        if (rv[i] && !(q.size() > 0 && q[0] == i)) stray = 1'b1;
      end
      if (pop) begin
        void'(q.pop_front());
        wait_cnt = 0;
      end else if (q.size() > 0) begin
        wait_cnt++;
      end
      if (e_g) begin
        q.push_back(tgt);
        last = tgt;
      end
    end
    apply(st(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, Z));
    n_cmp++;
    if (dut.stray_q !== stray) begin
      n_mis++;
      $display("FAIL random_stray: got %b, expected %b", dut.stray_q, stray);
    end
  endtask

  initial begin
    arstn_i          = 1'b0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = '0;
    bus.data_addr_i  = '0;
    bus.data_wdata_i = '0;
    slv_rvalid_i     = '0;
    slv_rdata_i      = '0;
    test_reset();
    test_read();
    test_decerr();
    test_full();
    test_switch();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
